pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the five-stage Y86-64 pipe.
- Generates per-cycle stall/bubble controls for the F, D, E, M and W pipeline registers from load-use, ret, mispredict and exception conditions.
- Holds an exception-drain FSM so a faulting instruction retires cleanly and the pipe freezes.
- Sits beside the stage registers; the E register consumes E_bubble from this block.

Parameters:
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
D_icode  in  4  icode in D register
d_srcA  in  4  decode srcA
d_srcB  in  4  decode srcB
E_icode  in  4  icode in E register
E_dstM  in  4  E-stage memory destination
e_Cnd  in  1  execute condition result
M_icode  in  4  icode in M register
m_stat  in  3  memory-stage status
W_stat  in  3  W register status
F_stall  out  1  hold F (PC) register
D_stall  out  1  hold D register
D_bubble  out  1  load nop into D
E_bubble  out  1  load nop into E
M_bubble  out  1  load nop into M
W_stall  out  1  hold W register
set_cc  out  1  condition codes may update this cycle
halted  out  1  pipe frozen after exception
exc_stat  out  3  status that caused halt
cnt_stall  out  CNT_W  load-use/ret stall cycles
cnt_mispred  out  CNT_W  mispredicted branches
cnt_cycles  out  CNT_W  cycles in RUN/DRAIN

Behaviour:
- Encodings are shared constants: stat AOK=1, HLT=2, ADR=3, INS=4; icode HALT=0, NOP=1, JXX=7, RET=9, OPQ=6, MRMOVQ=5, POPQ=B; RNONE=F.
- Conditions:
  - load_use = E_icode in {MRMOVQ,POPQ} && E_dstM!=RNONE && E_dstM in {d_srcA,d_srcB}.
  - ret_pend = RET in any of D_icode/E_icode/M_icode.
  - mispred = E_icode==JXX && !e_Cnd.
  - m_exc = m_stat in {ADR,INS,HLT}.
  - w_exc = W_stat in {ADR,INS,HLT}.
- RUN state; controls are combinational, same-cycle:
  - F_stall = load_use || ret_pend.
  - D_stall = load_use.
  - D_bubble = mispred || (ret_pend && !load_use).
  - E_bubble = mispred || load_use.
  - M_bubble = m_exc || w_exc.
  - W_stall = w_exc.
  - set_cc = E_icode==OPQ && !m_exc && !w_exc.
- Combined hazards:
  - load_use + ret_pend: stall wins; D_stall=1, D_bubble=0.
  - mispred + ret in D: D_bubble=1, E_bubble=1.
- FSM, 3 states:
  - RUN -> DRAIN when m_exc && !w_exc.
  - RUN -> HALTED when w_exc.
  - DRAIN -> HALTED when w_exc.
  - HALTED is sticky until rst.
- DRAIN outputs: F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1, set_cc=0. Only the faulting instruction advances.
- HALTED outputs:
  - F_stall=1, D_stall=1, E_bubble=1, M_bubble=1, W_stall=1, D_bubble=0, set_cc=0, halted=1.
  - exc_stat is registered from W_stat on the entering edge and held.
- Reset (asynchronous, takes effect immediately, including mid-DRAIN or in HALTED):
  - State=RUN, halted=0, exc_stat=AOK (3'h1), counters=0.
  - While rst=1, outputs are forced to F_stall=0, D_stall=0, D_bubble=1, E_bubble=1, M_bubble=1, W_stall=0, set_cc=0. This flushes the reset-less stage registers to nops.
- Counters:
  - Update on posedge, only when rst=0 and state!=HALTED; saturate at all-ones, no wrap.
  - cnt_stall increments when F_stall=1 in RUN.
  - cnt_mispred increments when mispred=1 in RUN.
  - cnt_cycles increments every RUN/DRAIN cycle.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined: counter logic is present as specified above.
- Undefined: the three counter registers are omitted; the cnt_* ports remain and are tied to 0.

Decomposition:
- Package pipe_pkg holds the stat codes, icode constants, RNONE, and the FSM state enum {ST_RUN, ST_DRAIN, ST_HALTED}.
- Sub-module sat_counter (width CNT_W, inc input, saturating) is instantiated three times under PIPE_PERF_CNT_EN.

Test Plan:
- Reset flush: assert rst for 2 cycles -> D_bubble=E_bubble=M_bubble=1, stalls=0, halted=0, exc_stat=1. Release -> RUN with all controls 0.
- Load-use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. cnt_stall increments by 1.
- Mispredict: E_icode=7, e_Cnd=0, D_icode=9 -> D_bubble=1, E_bubble=1, F_stall=1. cnt_mispred=1 after edge.
- Exception drain: m_stat=3 for one cycle, then W_stat=3 -> M_bubble=1 then halted=1, exc_stat=3, W_stall=1. Counters freeze thereafter.
- Reset in HALTED: assert rst asynchronously between edges -> halted drops immediately, state RUN, counters 0.
- Saturation (CNT_W=4): 20 load-use cycles -> cnt_stall=15, no wrap.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the Y86-64 pipeline control slice.
// Holds the status codes, instruction codes, the "no register" id and
// the control FSM state type. Imported by pipe_hazard_ctrl and its bench.
package pipe_pkg;

  localparam logic [2:0] STAT_AOK = 3'h1;
  localparam logic [2:0] STAT_HLT = 3'h2;
  localparam logic [2:0] STAT_ADR = 3'h3;
  localparam logic [2:0] STAT_INS = 3'h4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE    = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // True for any status that must stop the pipe.
  function automatic logic is_exc(input logic [2:0] s);
    return (s == STAT_ADR) || (s == STAT_INS) || (s == STAT_HLT);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for pipeline performance counters.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset (clears count)
//   inc  - count one on this edge
//   cnt  - current count; sticks at all-ones
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit for the five-stage Y86-64 pipe.
// Produces stall/bubble controls for F, D, E, M, W from load-use, ret,
// mispredict and exception conditions, and runs an exception-drain FSM
// (RUN -> DRAIN -> HALTED) so a faulting instruction retires and the pipe
// freezes until reset.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   D_icode, d_srcA, d_srcB      - decode-stage instruction and sources
//   E_icode, E_dstM, e_Cnd       - execute-stage instruction, load dest, cond
//   M_icode, m_stat, W_stat      - memory/writeback instruction and status
//   F_stall .. W_stall, set_cc   - pipeline register controls
//   halted, exc_stat             - frozen flag and the status that caused it
//   cnt_stall/mispred/cycles     - performance counters (CNT_W bits)
// Build option: define PIPE_PERF_CNT_EN to include the performance counters;
// without it the cnt_* outputs are tied to zero.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
  output logic [2:0]       exc_stat,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_mispred,
  output logic [CNT_W-1:0] cnt_cycles
);

  state_e state, state_nx;

  logic load_use;
  logic ret_pend;
  logic mispred;
  logic m_exc;
  logic w_exc;
  logic run_f_stall;

  always_comb begin
    load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
               (E_dstM != RNONE) &&
               ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret_pend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mispred  = (E_icode == I_JXX) && !e_Cnd;
    m_exc    = is_exc(m_stat);
    w_exc    = is_exc(W_stat);
    run_f_stall = load_use || ret_pend;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    set_cc   = 1'b0;

    case (state)
      ST_RUN: begin
        F_stall  = run_f_stall;
        D_stall  = load_use;
        // A pending ret bubbles D only when D is not already held by load-use.
        D_bubble = mispred || (ret_pend && !load_use);
        E_bubble = mispred || load_use;
        M_bubble = m_exc || w_exc;
        W_stall  = w_exc;
        set_cc   = (E_icode == I_OPQ) && !m_exc && !w_exc;
        if (w_exc) begin
          state_nx = ST_HALTED;
        end else if (m_exc) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Everything behind the faulting instruction is squashed so only
        // it moves on into W.
        F_stall  = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = w_exc;
        if (w_exc) begin
          state_nx = ST_HALTED;
        end
      end
      ST_HALTED: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
      end
      default: begin
        state_nx = ST_RUN;
      end
    endcase

    // Stage registers have no reset of their own; hold reset flushes them
    // to nops by bubbling D/E/M while nothing is stalled.
    if (rst) begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b0;
      set_cc   = 1'b0;
    end
  end

  assign halted = (state == ST_HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_stat <= STAT_AOK;
    end else if ((state != ST_HALTED) && (state_nx == ST_HALTED)) begin
      exc_stat <= W_stat;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic in_run;
  logic cnt_live;

  assign in_run   = (state == ST_RUN);
  assign cnt_live = (state != ST_HALTED);

  sat_counter #(.W(CNT_W)) u_cnt_stall (
    .clk (clk),
    .rst (rst),
    .inc (in_run && run_f_stall),
    .cnt (cnt_stall)
  );

  sat_counter #(.W(CNT_W)) u_cnt_mispred (
    .clk (clk),
    .rst (rst),
    .inc (in_run && mispred),
    .cnt (cnt_mispred)
  );

  sat_counter #(.W(CNT_W)) u_cnt_cycles (
    .clk (clk),
    .rst (rst),
    .inc (cnt_live),
    .cnt (cnt_cycles)
  );
`else
  assign cnt_stall   = '0;
  assign cnt_mispred = '0;
  assign cnt_cycles  = '0;
`endif

endmodule
